// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared constants and bus types for the write-back register file
//   Provides enable levels, zero word, register count/address width and
//   the RegisterBus / RegisterAddressBus types used by every file of the block.
package wb_regfile_pkg;
    localparam logic ResetEnable  = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;
    localparam int RegisterNum     = 32;
    localparam int RegisterNumLog2 = 5;
    typedef logic [31:0] RegisterBus;
    typedef logic [RegisterNumLog2-1:0] RegisterAddressBus;
    localparam RegisterBus        ZeroWord           = 32'h0;
    localparam RegisterAddressBus NOPRegisterAddress = 5'b0;
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: write-back / read-port bundle between pipeline and register file
//   master: stall, flush, write-back triple and read requests out; read data
//           and latched triple in.
//   slave : the register file side of the same signals.
interface wb_regfile_if
    import wb_regfile_pkg::*;
#(
    parameter int REG_ADDR_W = RegisterNumLog2,
    parameter int DATA_W     = 32
);
    logic                  stall;
    logic                  flush;
    logic [REG_ADDR_W-1:0] wd_input;
    logic                  wreg_input;
    logic [DATA_W-1:0]     wdata_input;
    logic                  re1_input;
    logic [REG_ADDR_W-1:0] raddr1_input;
    logic                  re2_input;
    logic [REG_ADDR_W-1:0] raddr2_input;
    logic [DATA_W-1:0]     rdata1_output;
    logic [DATA_W-1:0]     rdata2_output;
    logic [REG_ADDR_W-1:0] wd_output;
    logic                  wreg_output;
    logic [DATA_W-1:0]     wdata_output;
    modport master (
        output stall, flush, wd_input, wreg_input, wdata_input,
               re1_input, raddr1_input, re2_input, raddr2_input,
        input  rdata1_output, rdata2_output, wd_output, wreg_output, wdata_output
    );
    modport slave (
        input  stall, flush, wd_input, wreg_input, wdata_input,
               re1_input, raddr1_input, re2_input, raddr2_input,
        output rdata1_output, rdata2_output, wd_output, wreg_output, wdata_output
    );
endinterface

// File: rtl/wb_regfile_register_array.sv
// register_array: REG_NUM x DATA_W storage, one synchronous write port, two raw async reads
//   clock, reset      : rising-edge clock, synchronous active-high clear of every entry
//   we_i/waddr_i/wdata_i : write port; writes to address 0 are ignored
//   raddr*_i/rdata*_o : unfiltered read ports (no bypass, no zero forcing)
module register_array
    import wb_regfile_pkg::*;
#(
    parameter int REG_NUM    = RegisterNum,
    parameter int REG_ADDR_W = RegisterNumLog2,
    parameter int DATA_W     = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [REG_ADDR_W-1:0] raddr1_i,
    input  logic [REG_ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0]     rdata1_o,
    output logic [DATA_W-1:0]     rdata2_o
);
    logic [DATA_W-1:0] mem_q [REG_NUM];

    // A commit pending on the reset edge is dropped: reset wins over the write.
    always_ff @(posedge clock) begin
        if (reset == ResetEnable)
            for (int i = 0; i < REG_NUM; i++) mem_q[i] <= '0;
        else if (we_i == WriteEnable && waddr_i != '0)
            mem_q[waddr_i] <= wdata_i;
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back latch, register file commit and bypassed read ports
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : stall/flush, write-back triple in, latched triple out,
//                  two combinational read ports with bypass from the latch
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int REG_NUM    = RegisterNum,
    parameter int REG_ADDR_W = RegisterNumLog2,
    parameter int DATA_W     = 32
) (
    input  logic         clock,
    input  logic         reset,
    wb_regfile_if.slave  bus
);
    logic [REG_ADDR_W-1:0] wd_q, wd_d;
    logic                  wreg_q, wreg_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     raw1, raw2;
    logic                  pend;

    // flush beats stall; both beat a fresh load
    always_comb begin
        wd_d    = bus.flush ? '0 : bus.stall ? wd_q    : bus.wd_input;
        wreg_d  = bus.flush ? WriteDisable : bus.stall ? wreg_q : bus.wreg_input;
        wdata_d = bus.flush ? '0 : bus.stall ? wdata_q : bus.wdata_input;
    end

    always_ff @(posedge clock) begin
        if (reset == ResetEnable) begin
            wd_q    <= '0;
            wreg_q  <= WriteDisable;
            wdata_q <= '0;
        end else begin
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    // A latched write to register 0 is neither committed nor bypassed.
    assign pend = wreg_q && wd_q != '0;

    register_array #(
        .REG_NUM(REG_NUM), .REG_ADDR_W(REG_ADDR_W), .DATA_W(DATA_W)
    ) u_array (
        .clock    (clock),
        .reset    (reset),
        .we_i     (pend),
        .waddr_i  (wd_q),
        .wdata_i  (wdata_q),
        .raddr1_i (bus.raddr1_input),
        .raddr2_i (bus.raddr2_input),
        .rdata1_o (raw1),
        .rdata2_o (raw2)
    );

    // Bypass from the latch closes the one-cycle window before the array commit.
    assign bus.rdata1_output = (reset || bus.re1_input == ReadDisable || bus.raddr1_input == '0) ? '0 :
                               (pend && bus.raddr1_input == wd_q) ? wdata_q : raw1;
    assign bus.rdata2_output = (reset || bus.re2_input == ReadDisable || bus.raddr2_input == '0) ? '0 :
                               (pend && bus.raddr2_input == wd_q) ? wdata_q : raw2;

    assign bus.wd_output    = wd_q;
    assign bus.wreg_output  = wreg_q;
    assign bus.wdata_output = wdata_q;
endmodule
